// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory image loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_e;

  localparam int unsigned DEF_DWIDTH = 32;
  localparam int unsigned WORD_BYTES = DEF_DWIDTH / 8;

  // Byte stride between consecutive words for a given data width.
  function automatic int unsigned word_bytes(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/loader_csum.sv
// Write/read-back checksum pair; match_c_o already includes the read word being absorbed this cycle.
module loader_csum #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              wr_acc_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_acc_i,
  input  logic [DWIDTH-1:0] rd_data_i,
  output logic              match_c_o
);

  logic [DWIDTH-1:0] csum_w_q, csum_w_d;
  logic [DWIDTH-1:0] csum_r_q, csum_r_d;

  always_comb begin
    csum_w_d = csum_w_q;
    csum_r_d = csum_r_q;
    if (clr_i) begin
      csum_w_d = '0;
      csum_r_d = '0;
    end else begin
      if (wr_acc_i) csum_w_d = csum_w_q + wr_data_i;
      if (rd_acc_i) csum_r_d = csum_r_q + rd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_w_q <= '0;
      csum_r_q <= '0;
    end else begin
      csum_w_q <= csum_w_d;
      csum_r_q <= csum_r_d;
    end
  end

  assign match_c_o = (csum_r_d == csum_w_q);

endmodule

// File: rtl/imem_loader.sv
// Streams an instruction image into memory at BASE_ADDR and holds the core in reset until done.
// Optional read-back checksum verify enabled by IMEM_LOADER_VERIFY_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned             AWIDTH    = 32,
  parameter int unsigned             DWIDTH    = 32,
  parameter logic [AWIDTH-1:0]       BASE_ADDR = AWIDTH'(32'h0100_0000),
  parameter int unsigned             MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] num_words_i,
  input  logic [DWIDTH-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [AWIDTH-1:0] words_written_o,
  output logic              cpu_reset_o
);

  localparam logic [AWIDTH-1:0] STRIDE = AWIDTH'(word_bytes(DWIDTH));
  localparam logic [AWIDTH-1:0] MAX_N  = AWIDTH'(MAX_WORDS);

  loader_state_e     state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [AWIDTH-1:0] ww_q, ww_d;
  logic              hs_c;
  logic              last_c;
  logic [AWIDTH-1:0] addr_c;

  assign hs_c   = (state_q == ST_WRITE) && s_valid_i;
  assign last_c = (idx_q == cnt_q - AWIDTH'(1));
  assign addr_c = BASE_ADDR + idx_q * STRIDE;

`ifdef IMEM_LOADER_VERIFY_EN
  logic start_ok_c;
  logic rd_pend_q;
  logic sum_ok_c;

  assign start_ok_c = start_i &&
                      (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

  // Read data returns one cycle after each VERIFY read.
  always_ff @(posedge clk) begin
    if (reset) rd_pend_q <= 1'b0;
    else       rd_pend_q <= (state_q == ST_VERIFY);
  end

  loader_csum #(.DWIDTH(DWIDTH)) u_csum (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (start_ok_c),
    .wr_acc_i  (hs_c),
    .wr_data_i (s_data_i),
    .rd_acc_i  (rd_pend_q),
    .rd_data_i (mem_data_i),
    .match_c_o (sum_ok_c)
  );
`else
  logic unused_rd_c;
  assign unused_rd_c = ^mem_data_i;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ww_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ww_q    <= ww_d;
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ww_d    = ww_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          if (num_words_i == '0) begin
            state_d = ST_DONE;
            ww_d    = '0;
          end else if (num_words_i > MAX_N) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_WRITE;
            cnt_d   = num_words_i;
            idx_d   = '0;
            ww_d    = '0;
          end
        end
      end
      ST_WRITE: begin
        if (hs_c) begin
          idx_d = idx_q + AWIDTH'(1);
          ww_d  = ww_q + AWIDTH'(1);
          if (last_c) begin
`ifdef IMEM_LOADER_VERIFY_EN
            state_d = ST_VERIFY;
            idx_d   = '0;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        idx_d = idx_q + AWIDTH'(1);
        if (last_c) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = sum_ok_c ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Port outputs; memory port is driven to zero whenever the loader is not busy.
  always_comb begin
    s_ready_o      = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    error_o        = 1'b0;
    cpu_reset_o    = 1'b1;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    case (state_q)
      ST_WRITE: begin
        s_ready_o = 1'b1;
        busy_o    = 1'b1;
        if (s_valid_i) begin
          mem_write_en_o = 1'b1;
          mem_addr_o     = addr_c;
          mem_data_o     = s_data_i;
        end
      end
`ifdef IMEM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        busy_o        = 1'b1;
        mem_read_en_o = 1'b1;
        mem_addr_o    = addr_c;
      end
      ST_CHECK: busy_o = 1'b1;
`endif
      ST_DONE: begin
        done_o      = 1'b1;
        cpu_reset_o = 1'b0;
      end
      ST_ERROR: error_o = 1'b1;
      default: ;
    endcase
  end

  assign words_written_o = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes/reads queued at stimulus, checked at the memory port.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [31:0] num_words_i;
  logic [31:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [31:0] mem_data_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [31:0] words_written_o;
  logic        cpu_reset_o;

  imem_loader dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .num_words_i     (num_words_i),
    .s_data_i        (s_data_i),
    .s_valid_i       (s_valid_i),
    .s_ready_o       (s_ready_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_read_en_o   (mem_read_en_o),
    .mem_write_en_o  (mem_write_en_o),
    .mem_data_i      (mem_data_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .words_written_o (words_written_o),
    .cpu_reset_o     (cpu_reset_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_wr     = 0;
  int          widx     = 0;
  int          wr_cyc_q[$];
  wr_t         exp_q[$];
  logic [31:0] rd_exp_q[$];
  wr_t         e;
  logic [31:0] ra;
  logic [31:0] mem [0:63];
  logic        corrupt = 1'b0;
  logic [31:0] rdata_q = '0;

  assign mem_data_i = rdata_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] midx(input logic [31:0] a);
    logic [31:0] t;
    t = (a - BASE) >> 2;
    return t[5:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model; optionally corrupts word 1 on read-back.
  always @(posedge clk) begin
    if (mem_write_en_o) mem[midx(mem_addr_o)] <= mem_data_o;
    if (mem_read_en_o)
      rdata_q <= mem[midx(mem_addr_o)] ^ ((corrupt && midx(mem_addr_o) == 6'd1) ? 32'h1 : 32'h0);
    else
      rdata_q <= '0;
  end

  // Port monitor: every write/read must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (!reset && mem_write_en_o) begin
      n_wr++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr_o), 64'(e.addr));
        chk("wr_data", 64'(mem_data_o), 64'(e.data));
      end
    end
    if (!reset && mem_read_en_o) begin
      if (rd_exp_q.size() == 0) begin
        chk("rd_unexpected", 64'(rd_exp_q.size()), 64'd1);
      end else begin
        ra = rd_exp_q.pop_front();
        chk("rd_addr", 64'(mem_addr_o), 64'(ra));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] n);
    start_i     = 1'b1;
    num_words_i = n;
    tick();
    start_i = 1'b0;
    widx    = 0;
  endtask

  task automatic send_word(input logic [31:0] d);
    s_data_i  = d;
    s_valid_i = 1'b1;
    exp_q.push_back('{addr: BASE + 32'(widx * 4), data: d});
    widx++;
    tick();
    s_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int k;
    reset       = 1'b1;
    start_i     = 1'b0;
    num_words_i = '0;
    s_data_i    = '0;
    s_valid_i   = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(s_ready_o), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset_o), 64'd1);
    chk("rst_done_err", 64'({done_o, error_o}), 64'd0);
    chk("rst_ww", 64'(words_written_o), 64'd0);
    reset = 1'b0;
    tick();

    // Back-to-back N=4
    start_load(4);
    chk("t1_ready", 64'(s_ready_o), 64'd1);
    wr_cyc_q.delete();
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_word(32'h0020_0113);
    send_word(32'h0030_8193);
    chk("t1_done", 64'(done_o), 64'd1);
    chk("t1_cpu_reset", 64'(cpu_reset_o), 64'd0);
    chk("t1_ww", 64'(words_written_o), 64'd4);
    chk("t1_ready_drop", 64'(s_ready_o), 64'd0);
    chk("t1_nwr", 64'(wr_cyc_q.size()), 64'd4);
    if (wr_cyc_q.size() == 4) chk("t1_span", 64'(wr_cyc_q[3] - wr_cyc_q[0]), 64'd3);
    chk("t1_mem3", 64'(mem[3]), 64'h0030_8193);
    chk("t1_sb", 64'(exp_q.size()), 64'd0);

    // N=3 with a 2-cycle stall
    n0 = n_wr;
    start_load(3);
    send_word(32'hAAAA_0001);
    send_word(32'hAAAA_0002);
    repeat (2) begin
      tick();
      chk("t2_stall_ready", 64'(s_ready_o), 64'd1);
    end
    send_word(32'hAAAA_0003);
    chk("t2_done", 64'(done_o), 64'd1);
    chk("t2_nwr", 64'(n_wr - n0), 64'd3);
    chk("t2_ww", 64'(words_written_o), 64'd3);

    // N=0 and N=MAX_WORDS+1
    n0 = n_wr;
    start_load(0);
    chk("t3_zero_done", 64'(done_o), 64'd1);
    chk("t3_zero_busy", 64'(busy_o), 64'd0);
    start_load(1025);
    chk("t3_big_err", 64'(error_o), 64'd1);
    chk("t3_big_cpu_reset", 64'(cpu_reset_o), 64'd1);
    chk("t3_big_done", 64'(done_o), 64'd0);
    tick();
    chk("t3_big_ready", 64'(s_ready_o), 64'd0);
    chk("t3_nwr", 64'(n_wr - n0), 64'd0);

    // Reset after 2 of 4 words, then a fresh N=2 load
    start_load(4);
    send_word(32'h1111_0000);
    send_word(32'h1111_0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_busy", 64'(busy_o), 64'd0);
    chk("t4_cpu_reset", 64'(cpu_reset_o), 64'd1);
    chk("t4_ww", 64'(words_written_o), 64'd0);
    chk("t4_ready", 64'(s_ready_o), 64'd0);
    start_load(2);
    send_word(32'h2222_0000);
    send_word(32'h2222_0001);
    chk("t4_done", 64'(done_o), 64'd1);
    chk("t4_ww2", 64'(words_written_o), 64'd2);

    // start_i pulsed mid-WRITE is ignored
    start_load(4);
    send_word(32'h3333_0000);
    start_i     = 1'b1;
    num_words_i = 32'd2;
    send_word(32'h3333_0001);
    start_i = 1'b0;
    chk("t5_busy", 64'(busy_o), 64'd1);
    send_word(32'h3333_0002);
    chk("t5_still_busy", 64'(busy_o), 64'd1);
    send_word(32'h3333_0003);
    chk("t5_done", 64'(done_o), 64'd1);
    chk("t5_ww", 64'(words_written_o), 64'd4);
    chk("t5_sb", 64'(exp_q.size()), 64'd0);

`ifdef IMEM_LOADER_VERIFY_EN
    // Verify pass with correct memory
    corrupt = 1'b0;
    rd_exp_q.push_back(BASE);
    rd_exp_q.push_back(BASE + 32'd4);
    start_load(2);
    send_word(32'h4444_0001);
    send_word(32'h4444_0002);
    chk("v1_read_en", 64'(mem_read_en_o), 64'd1);
    k = 0;
    while (!(done_o || error_o) && k < 20) begin
      tick();
      k++;
    end
    chk("v1_lat", 64'(k), 64'd3);
    chk("v1_done", 64'(done_o), 64'd1);
    chk("v1_err", 64'(error_o), 64'd0);
    chk("v1_rd_sb", 64'(rd_exp_q.size()), 64'd0);

    // Verify pass with word 1 corrupted on read-back
    corrupt = 1'b1;
    rd_exp_q.push_back(BASE);
    rd_exp_q.push_back(BASE + 32'd4);
    start_load(2);
    send_word(32'h5555_0001);
    send_word(32'h5555_0002);
    k = 0;
    while (!(done_o || error_o) && k < 20) begin
      tick();
      k++;
    end
    chk("v2_err", 64'(error_o), 64'd1);
    chk("v2_done", 64'(done_o), 64'd0);
    chk("v2_cpu_reset", 64'(cpu_reset_o), 64'd1);
    corrupt = 1'b0;
`endif

    tick();
    chk("final_sb", 64'(exp_q.size() + rd_exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
